// File: rtl/mine_field_gen_if.sv
// Request/status/read-port bundle for mine_field_gen; master drives requests and read addresses.
interface mine_field_gen_if #(
    parameter int MAX_DIM = 16,
    parameter int MINE_W  = 8
);
    localparam int K = $clog2(MAX_DIM);

    logic              start;
    logic [4:0]        dimension_size;
    logic [MINE_W-1:0] mines;
    logic [K-1:0]      safe_x;
    logic [K-1:0]      safe_y;
    logic [K-1:0]      rd_x;
    logic [K-1:0]      rd_y;
    logic              rd_mine;
    logic              busy;
    logic              done;
    logic              err;
    logic [MINE_W-1:0] mines_placed;

    modport master (
        output start, dimension_size, mines, safe_x, safe_y, rd_x, rd_y,
        input  rd_mine, busy, done, err, mines_placed
    );

    modport slave (
        input  start, dimension_size, mines, safe_x, safe_y, rd_x, rd_y,
        output rd_mine, busy, done, err, mines_placed
    );
endinterface

// File: rtl/mine_field_gen.sv
// Random mine-field generator: MAX_DIM row-clear cycles, then one LFSR candidate per cycle; start ignored while busy.
// MINE_SAFE_ZONE_EN widens the first-click exclusion from one cell to the clipped 3x3 block around it.
module mine_field_gen #(
    parameter int          MAX_DIM = 16,
    parameter int          MINE_W  = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    mine_field_gen_if.slave  io
);
    localparam int          K     = $clog2(MAX_DIM);
    localparam logic [31:0] MAX_U = MAX_DIM;

    typedef enum logic [1:0] {IDLE, CLEAR, PLACE} state_t;

    state_t            state, state_nxt;
    logic [15:0]       lfsr;
    logic [MAX_DIM-1:0] field [MAX_DIM];
    logic [K-1:0]      clr_row;
    logic [4:0]        dim_l;
    logic [MINE_W-1:0] mines_l;
    logic [MINE_W-1:0] placed;
    logic [K-1:0]      sx_l, sy_l;
    logic              err_q;
    logic              rd_q;
    logic              clear_en, place_en, done_place;

    // Request validation against the capacity left after exclusion
    logic [10:0] sq, excl, cap;
    logic        reject, accept, rej_start;

`ifdef MINE_SAFE_ZONE_EN
    function automatic logic [1:0] axis_span(input logic [5:0] c, input logic [5:0] d);
        logic [5:0] lo, hi;
        lo = (c == 6'd0) ? 6'd0 : c - 6'd1;
        hi = (c + 6'd1 > d - 6'd1) ? d - 6'd1 : c + 6'd1;
        if (d == 6'd0 || hi < lo) return 2'd0;
        return 2'(hi - lo + 6'd1);
    endfunction

    assign excl = 11'(axis_span(6'(io.safe_x), 6'(io.dimension_size)))
                * 11'(axis_span(6'(io.safe_y), 6'(io.dimension_size)));
`else
    assign excl = 11'd1;
`endif

    assign sq        = 11'(io.dimension_size) * 11'(io.dimension_size);
    assign cap       = sq - excl;
    assign reject    = (io.dimension_size < 5'd2) || (32'(io.dimension_size) > MAX_U)
                     || (32'(io.mines) > 32'(cap));
    assign accept    = (state == IDLE) && io.start && !reject;
    assign rej_start = (state == IDLE) && io.start && reject;

    // Candidate cell drawn from the low LFSR bits
    logic [K-1:0] cx, cy;
    logic         in_board, excluded, take;

    assign cx       = lfsr[K-1:0];
    assign cy       = lfsr[2*K-1:K];
    assign in_board = (6'(cx) < 6'(dim_l)) && (6'(cy) < 6'(dim_l));
`ifdef MINE_SAFE_ZONE_EN
    assign excluded = (7'(cx) + 7'd1 >= 7'(sx_l)) && (7'(cx) <= 7'(sx_l) + 7'd1)
                   && (7'(cy) + 7'd1 >= 7'(sy_l)) && (7'(cy) <= 7'(sy_l) + 7'd1);
`else
    assign excluded = (cx == sx_l) && (cy == sy_l);
`endif
    assign take     = in_board && !excluded && !field[cy][cx];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        clear_en   = 1'b0;
        place_en   = 1'b0;
        done_place = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = CLEAR;
            CLEAR: begin
                clear_en = 1'b1;
                if (clr_row == K'(MAX_DIM - 1)) state_nxt = PLACE;
            end
            PLACE: begin
                if (placed == mines_l) begin
                    done_place = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    place_en = take;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= SEED;
            clr_row <= '0;
            dim_l   <= '0;
            mines_l <= '0;
            sx_l    <= '0;
            sy_l    <= '0;
            placed  <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) field[r] <= '0;
        end else begin
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            err_q <= rej_start;
            rd_q  <= ((32'(io.rd_x) < MAX_U) && (32'(io.rd_y) < MAX_U)) ? field[io.rd_y][io.rd_x] : 1'b0;
            if (accept) begin
                dim_l   <= io.dimension_size;
                mines_l <= io.mines;
                sx_l    <= io.safe_x;
                sy_l    <= io.safe_y;
                clr_row <= '0;
            end
            if (clear_en) begin
                field[clr_row] <= '0;
                clr_row        <= clr_row + K'(1);
                placed         <= '0;
            end
            if (place_en) begin
                field[cy][cx] <= 1'b1;
                placed        <= placed + MINE_W'(1);
            end
        end
    end

    assign io.busy         = (state != IDLE);
    assign io.done         = done_place | err_q;
    assign io.err          = err_q;
    assign io.rd_mine      = rd_q;
    assign io.mines_placed = placed;
endmodule

// File: tb/tb_mine_field_gen.sv
// Randomized self-checking bench for mine_field_gen against a rule-level field model.
module tb_mine_field_gen;
    localparam int MAX_DIM = 16;
    localparam int MINE_W  = 8;
    localparam int K       = $clog2(MAX_DIM);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mine_field_gen_if #(.MAX_DIM(MAX_DIM), .MINE_W(MINE_W)) io();

    mine_field_gen #(.MAX_DIM(MAX_DIM), .MINE_W(MINE_W), .SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int mdl_placed = 0;
    bit shadow [MAX_DIM][MAX_DIM];
    bit cur    [MAX_DIM][MAX_DIM];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic bit is_excl(input int x, input int y, input int sx, input int sy);
`ifdef MINE_SAFE_ZONE_EN
        return (x >= sx - 1) && (x <= sx + 1) && (y >= sy - 1) && (y <= sy + 1);
`else
        return (x == sx) && (y == sy);
`endif
    endfunction

    function automatic int cap_of(input int dim, input int sx, input int sy);
`ifdef MINE_SAFE_ZONE_EN
        int n = 0;
        for (int y = 0; y < dim; y++)
            for (int x = 0; x < dim; x++)
                if (is_excl(x, y, sx, sy)) n++;
        return dim * dim - n;
`else
        return dim * dim - 1;
`endif
    endfunction

    task automatic read_all(input int dim, input int sx, input int sy,
                            output int cnt, output int n_excl, output int n_oob, output int n_diff);
        cnt = 0; n_excl = 0; n_oob = 0; n_diff = 0;
        for (int y = 0; y < MAX_DIM; y++) begin
            for (int x = 0; x < MAX_DIM; x++) begin
                @(negedge clk);
                io.rd_x = x[K-1:0];
                io.rd_y = y[K-1:0];
                @(negedge clk);
                cur[y][x] = io.rd_mine;
                if (cur[y][x]) begin
                    cnt++;
                    if (x >= dim || y >= dim) n_oob++;
                    if (is_excl(x, y, sx, sy)) n_excl++;
                end
                if (cur[y][x] != shadow[y][x]) n_diff++;
            end
        end
    endtask

    task automatic wait_done(input int budget, input int poke_at,
                             output int cycles, output int ndone, output int busy_low, output bit timed_out);
        cycles = 1; ndone = 0; busy_low = 0; timed_out = 1'b0;
        forever begin
            if (!io.busy) busy_low++;
            if (io.done) begin
                ndone++;
                break;
            end
            if (cycles >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            io.start = (cycles == poke_at);
            if (cycles == poke_at) begin
                io.dimension_size = 5'd4;
                io.mines          = 8'd1;
            end
            cycles++;
        end
        io.start = 1'b0;
    endtask

    task automatic gen(input string tag, input int dim, input int m, input int sx, input int sy,
                       input int poke_at, input int exp_cycles);
        int  c, cycles, ndone, blow, cnt, nex, noob, ndiff, xdone, xbusy;
        bit  to, rej;
        c   = cap_of(dim, sx, sy);
        rej = (dim < 2) || (dim > MAX_DIM) || (m > c);
        @(negedge clk);
        io.dimension_size = dim[4:0];
        io.mines          = m[MINE_W-1:0];
        io.safe_x         = sx[K-1:0];
        io.safe_y         = sy[K-1:0];
        io.start          = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        if (rej) begin
            check({tag, "_err"},  io.err,  1);
            check({tag, "_done"}, io.done, 1);
            check({tag, "_busy"}, io.busy, 0);
            @(negedge clk);
            check({tag, "_err_end"},  io.err,  0);
            check({tag, "_done_end"}, io.done, 0);
            check({tag, "_busy_end"}, io.busy, 0);
            check({tag, "_placed_kept"}, io.mines_placed, mdl_placed);
            read_all(dim, sx, sy, cnt, nex, noob, ndiff);
            check({tag, "_field_kept"}, ndiff, 0);
        end else begin
            check({tag, "_busy_start"}, io.busy, 1);
            check({tag, "_err_start"},  io.err,  0);
            wait_done(5000, poke_at, cycles, ndone, blow, to);
            check({tag, "_timeout"}, to, 0);
            check({tag, "_busy_hold"}, blow, 0);
            check({tag, "_err_at_done"}, io.err, 0);
            if (exp_cycles > 0) check({tag, "_latency"}, cycles, exp_cycles);
            check({tag, "_lat_min"}, int'(cycles >= MAX_DIM + 1 + m), 1);
            check({tag, "_placed"}, io.mines_placed, m);
            xdone = 0; xbusy = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (io.done) xdone++;
                if (io.busy) xbusy++;
            end
            check({tag, "_extra_done"}, xdone, 0);
            check({tag, "_busy_after"}, xbusy, 0);
            read_all(dim, sx, sy, cnt, nex, noob, ndiff);
            check({tag, "_count"}, cnt, m);
            check({tag, "_excl_hits"}, nex, 0);
            check({tag, "_oob_hits"}, noob, 0);
            shadow     = cur;
            mdl_placed = m;
        end
    endtask

    initial begin
        int cnt, nex, noob, ndiff, dim, c, m, sx, sy;
        rst = 1'b1;
        io.start = 1'b0; io.dimension_size = '0; io.mines = '0;
        io.safe_x = '0; io.safe_y = '0; io.rd_x = '0; io.rd_y = '0;
        for (int y = 0; y < MAX_DIM; y++)
            for (int x = 0; x < MAX_DIM; x++) shadow[y][x] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy",   io.busy, 0);
        check("rst_done",   io.done, 0);
        check("rst_err",    io.err,  0);
        check("rst_placed", io.mines_placed, 0);
        check("rst_rd",     io.rd_mine, 0);
        read_all(MAX_DIM, 0, 0, cnt, nex, noob, ndiff);
        check("rst_field", cnt, 0);

        gen("basic", 8, 10, 3, 3, -1, -1);
        gen("full_rej", 8, 64, 3, 3, -1, -1);
        gen("zero", 16, 0, 5, 7, -1, MAX_DIM + 1);
        gen("midrun", 10, 40, $urandom_range(0, 9), $urandom_range(0, 9), 30, -1);

        // reset while placing aborts the run and empties the field
        @(negedge clk);
        io.dimension_size = 5'd16; io.mines = 8'd100;
        io.safe_x = 4'd5; io.safe_y = 4'd5; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (24) @(negedge clk);
        check("abort_pre_busy", io.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   io.busy, 0);
        check("abort_placed", io.mines_placed, 0);
        check("abort_done",   io.done, 0);
        for (int y = 0; y < MAX_DIM; y++)
            for (int x = 0; x < MAX_DIM; x++) shadow[y][x] = 1'b0;
        mdl_placed = 0;
        read_all(MAX_DIM, 5, 5, cnt, nex, noob, ndiff);
        check("abort_field", cnt, 0);
        gen("after_abort", 12, 20, 0, 11, -1, -1);

        gen("dim1",  1, 0, 0, 0, -1, -1);
        gen("dim17", 17, 5, 2, 2, -1, -1);
        gen("dim0",  0, 0, 0, 0, -1, -1);

        for (int i = 0; i < 8; i++) begin
            dim = $urandom_range(0, 18);
            sx  = $urandom_range(0, MAX_DIM - 1);
            sy  = $urandom_range(0, MAX_DIM - 1);
            c   = cap_of(dim, sx, sy);
            if ($urandom_range(0, 3) == 0 && c >= 0 && c < 255) m = c + 1;
            else m = $urandom_range(0, (c > 1) ? c / 2 : 0);
            if (m > 255) m = 255;
            gen($sformatf("rnd%0d", i), dim, m, sx, sy, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mine_field_gen.md
MINE_FIELD_GEN -- requirements
Module: mine_field_gen

Interface
REQ-001 SHALL have parameter MAX_DIM, default 16; maximum board side, 2..32.
REQ-002 SHALL have parameter MINE_W, default 8; width of mine-count signals.
REQ-003 SHALL have parameter SEED, default 16'hACE1; LFSR reset value, nonzero.
REQ-004 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to generate a new field.
REQ-008 dimension_size  input  5  board side, sampled on start.
REQ-009 mines  input  MINE_W  requested mine count, sampled on start.
REQ-010 safe_x, safe_y  input  clog2(MAX_DIM) each  first-click cell, sampled on start.
REQ-011 rd_x, rd_y  input  clog2(MAX_DIM) each  read-port coordinates.
REQ-012 rd_mine  output  1  mine flag at (rd_x,rd_y), registered.
REQ-013 busy  output  1  generation in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle pulse, with done, on rejected request.
REQ-016 mines_placed  output  MINE_W  mines placed in the current field.

Function
REQ-017 SHALL hold a MAX_DIM x MAX_DIM mine bit array internally.
REQ-018 SHALL run a free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing every cycle outside reset.
REQ-019 SHALL implement FSM IDLE -> CLEAR -> PLACE -> IDLE.
REQ-020 start in IDLE SHALL latch inputs and enter CLEAR next cycle; start while busy SHALL be ignored.
REQ-021 Request SHALL be rejected if dimension_size<2, dimension_size>MAX_DIM, or mines>capacity (REQ-031); rejection: stay IDLE, pulse done and err the cycle after start, array and mines_placed unchanged.
REQ-022 CLEAR SHALL zero one row per cycle, taking MAX_DIM cycles, and SHALL reset mines_placed to 0.
REQ-023 PLACE SHALL form candidate x=lfsr[K-1:0], y=lfsr[2K-1:K], K=clog2(MAX_DIM), once per cycle.
REQ-024 Candidate SHALL be rejected if x or y >= dimension_size, the cell already holds a mine, or the cell is excluded (REQ-031).
REQ-025 Accepted candidate SHALL set its bit and increment mines_placed in the same cycle.
REQ-026 When mines_placed equals the latched mines, FSM SHALL return to IDLE and pulse done that cycle; mines=0 SHALL finish on the first PLACE cycle with no bits set.
REQ-027 busy SHALL be high from the cycle after an accepted start through the done cycle inclusive.
REQ-028 rd_mine SHALL equal the array bit addressed by rd_x/rd_y one cycle earlier; reads SHALL be legal while busy; out-of-range addresses SHALL read 0.
REQ-029 Placed field SHALL never hold more than mines bits nor any excluded cell.

Reset
REQ-030 rst SHALL force IDLE, clear the array, load LFSR with SEED, drive busy, done, err, rd_mine and mines_placed to 0, aborting any generation in progress.

Configuration
REQ-031 Macro MINE_SAFE_ZONE_EN defined: excluded cells are the 3x3 block centred on (safe_x,safe_y), clipped to the board, and capacity = dimension_size^2 - clipped block size; undefined: only (safe_x,safe_y) is excluded and capacity = dimension_size^2 - 1.

Verification
REQ-032 Reset, dim=8, mines=10, safe=(3,3), start -> busy next cycle, done within 5000 cycles, mines_placed=10, exactly 10 bits read back, none at (3,3) (none in rows/cols 2..4 with MINE_SAFE_ZONE_EN).
REQ-033 dim=16, mines=0 -> done after exactly MAX_DIM CLEAR cycles plus 1 PLACE cycle, all 256 reads 0.
REQ-034 dim=8, mines=64 -> err and done pulse the cycle after start, busy never high, previous field intact.
REQ-035 dim=10, mines=40, second start pulsed mid-run -> ignored, single done, mines_placed=40, no reads at x>=10 or y>=10 return 1.
REQ-036 Assert rst during PLACE -> next cycle busy=0, mines_placed=0, all reads 0; new start completes normally.
REQ-037 dim=1 or dim=17 with MAX_DIM=16 -> err pulse, no state change.
